sram_ctrl: RTL and testbench

Parametrised async-SRAM controller, the next generation of the board's SRAM interface. Byte-addressed host port with req/ready/ack handshake; bus width, lane count and wait states are configurable. Built-in program loader takes a generic byte stream (UART receiver or other source outside this block) in the format: 4-byte address, 4-byte count, then data. The block drives the external SRAM pins directly.

---
 rtl/sram_ctrl_pkg.sv | 34 +++
 rtl/sram_loader.sv | 110 +++++++++++
 rtl/sram_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the async-SRAM controller.
//   eng_state_t : access engine states
//   ld_state_t  : program-loader states (8 header bytes, then data)
//   HDR_BYTES   : loader header length in bytes (4 address + 4 count)
//   lane_index  : byte lane carrying a given low address (lane 0 = D[7:0])
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    DONE
  } eng_state_t;

  // Header states are numbered 0..HDR_BYTES-1 in stream order.
  typedef enum logic [3:0] {
    HDR_A0,
    HDR_A1,
    HDR_A2,
    HDR_A3,
    HDR_C0,
    HDR_C1,
    HDR_C2,
    HDR_C3,
    DATA
  } ld_state_t;

  localparam int HDR_BYTES = 8;

  // Big-endian lane order: the lowest byte address sits in the top lane.
  function automatic int lane_index(input int lanes, input int low_addr);
    return lanes - 1 - low_addr;
  endfunction

endpackage

// File: rtl/sram_loader.sv
// Program loader: parses a byte stream "addr[31:0], count[31:0], data..."
// (both header words big-endian) and turns each data byte into one write
// request for the access engine.
// Ports:
//   clock, resetn          clock, async active-low reset
//   prog                   loader enabled; when low the parser is held in HDR_A0
//   ld_valid/ld_data/ld_ready  byte stream handshake
//   prog_busy              data phase with bytes still expected
//   prog_done              one-cycle pulse when a block has been fully written
//   engine_idle/engine_done  engine status (IDLE / DONE state)
//   load_req/load_addr/load_data  write request to the engine
module sram_loader
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 19
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              prog,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              prog_busy,
  output logic              prog_done,
  input  logic              engine_idle,
  input  logic              engine_done,
  output logic              load_req,
  output logic [ADDR_W-1:0] load_addr,
  output logic [7:0]        load_data
);

  ld_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       count_reg, count_next;
  logic [31:0]       count_shift;
  logic              done_reg, done_next;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= HDR_A0;
      addr_reg  <= '0;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    count_next  = count_reg;
    done_next   = 1'b0;
    ld_ready    = 1'b0;
    load_req    = 1'b0;
    count_shift = {count_reg[23:0], ld_data};
    if (!prog) begin
      state_next = HDR_A0;
    end else begin
      unique case (state_reg)
        DATA: begin
          if (count_reg != '0) begin
            // A byte is only taken when the engine can start its write
            // on the same edge, so no data buffering is needed.
            ld_ready = engine_idle;
            if (ld_valid && engine_idle) begin
              load_req   = 1'b1;
              addr_next  = addr_reg + ADDR_W'(1);
              count_next = count_reg - 32'd1;
            end
          end else if (engine_done) begin
            done_next  = 1'b1;
            state_next = HDR_A0;
          end
        end
        default: begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            // Shifting into an ADDR_W-wide register drops the address
            // bits above ADDR_W for free.
            if (state_reg < HDR_C0) begin
              addr_next = ADDR_W'({addr_reg, ld_data});
            end else begin
              count_next = count_shift;
            end
            if (int'(state_reg) == HDR_BYTES - 1) begin
              if (count_shift == '0) begin
                done_next  = 1'b1;
                state_next = HDR_A0;
              end else begin
                state_next = DATA;
              end
            end else begin
              state_next = ld_state_t'(state_reg + 4'd1);
            end
          end
        end
      endcase
    end
  end

  assign prog_busy = (state_reg == DATA) && (count_reg != '0);
  assign prog_done = done_reg;
  assign load_addr = addr_reg;
  assign load_data = ld_data;

endmodule

// File: rtl/sram_ctrl.sv
// Async-SRAM controller with byte-addressed host port and built-in loader.
// Ports:
//   clock, resetn                 clock, async active-low reset
//   req/we/address/indata         host request (accepted when ready=1)
//   ready, ack, outdata           host status, completion pulse, read byte
//   prog, ld_valid/ld_data/ld_ready, prog_busy, prog_done  loader side
//   SRAM_A, SRAM_D, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_BE_n  SRAM pins
// Each access: STROBE for WAIT_CYCLES+1 cycles, then DONE for one cycle.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int BUS_W       = 16,
  parameter int WAIT_CYCLES = 1,
  localparam int LANES      = BUS_W / 8,
  localparam int LSB        = $clog2(LANES)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     address,
  input  logic [7:0]            indata,
  output logic                  ready,
  output logic                  ack,
  output logic [7:0]            outdata,
  input  logic                  prog,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  output logic                  prog_busy,
  output logic                  prog_done,
  output logic [ADDR_W-LSB-1:0] SRAM_A,
  inout  wire  [BUS_W-1:0]      SRAM_D,
  output logic                  SRAM_CE_n,
  output logic                  SRAM_OE_n,
  output logic                  SRAM_WE_n,
  output logic [LANES-1:0]      SRAM_BE_n
);

  localparam int LSB_W = (LSB > 0) ? LSB : 1;

  eng_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic [7:0]        rdata_reg, rdata_next;
  logic              we_reg, we_next;
  logic              host_reg, host_next;   // access belongs to the host
  logic [3:0]        wait_reg, wait_next;
  logic              init_reg;              // keeps ready low one cycle after reset

  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              host_acc, start;
  logic [LSB_W-1:0]  low_addr, lane_sel;
  logic [7:0]        lane_bytes [LANES];
  logic [BUS_W-1:0]  wdata_bus;
  logic              strobe_wr;

  sram_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clock       (clock),
    .resetn      (resetn),
    .prog        (prog),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .prog_busy   (prog_busy),
    .prog_done   (prog_done),
    .engine_idle (state_reg == IDLE),
    .engine_done (state_reg == DONE),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  // The loader only requests while prog=1, when ready is forced low, so the
  // two request sources never collide.
  assign host_acc = req && ready;
  assign start    = host_acc || load_req;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      we_reg    <= 1'b0;
      host_reg  <= 1'b0;
      wait_reg  <= '0;
      init_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      we_reg    <= we_next;
      host_reg  <= host_next;
      wait_reg  <= wait_next;
      init_reg  <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    we_next    = we_reg;
    host_next  = host_reg;
    wait_next  = wait_reg;
    unique case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          state_next = STROBE;
          wait_next  = '0;
          addr_next  = host_acc ? address : load_addr;
          wdata_next = host_acc ? indata : load_data;
          we_next    = host_acc ? we : 1'b1;
          host_next  = host_acc;
        end
      end
      STROBE: begin
        if (wait_reg == 4'(WAIT_CYCLES)) begin
          state_next = DONE;
          if (!we_reg) rdata_next = lane_bytes[lane_sel];
        end else begin
          wait_next = wait_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    if (LSB > 0) begin : g_low
      assign low_addr = addr_reg[LSB-1:0];
    end else begin : g_nolow
      assign low_addr = '0;
    end
  endgenerate

  assign lane_sel = LSB_W'(lane_index(LANES, int'(low_addr)));

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_bytes[gi]       = SRAM_D[8*gi +: 8];
      assign wdata_bus[8*gi +: 8] = wdata_reg;
      assign SRAM_BE_n[gi]        = !((state_reg == STROBE) && (lane_sel == LSB_W'(gi)));
    end
  endgenerate

  // Strobes decode straight from the state register so an asynchronous
  // reset releases the bus immediately.
  assign strobe_wr = (state_reg == STROBE) && we_reg;
  assign SRAM_D    = strobe_wr ? wdata_bus : 'z;
  assign SRAM_A    = addr_reg[ADDR_W-1:LSB];
  assign SRAM_CE_n = 1'b0;
  assign SRAM_WE_n = !strobe_wr;
  assign SRAM_OE_n = !((state_reg == STROBE) && !we_reg);

  // During a loader write that finishes after prog drops, the host waits
  // for IDLE; host completions may overlap the next accept.
  assign ready   = init_reg && !prog &&
                   ((state_reg == IDLE) || ((state_reg == DONE) && host_reg));
  assign ack     = (state_reg == DONE) && host_reg;
  assign outdata = rdata_reg;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

  localparam int ADDR_W = 19;
  localparam int BUS_W  = 16;
  localparam int LANES  = 2;
  localparam int LSB    = 1;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [7:0]        indata = '0;
  logic              ready, ack;
  logic [7:0]        outdata;
  logic              prog = 1'b0;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_data = '0;
  logic              ld_ready, prog_busy, prog_done;
  logic [ADDR_W-LSB-1:0] sram_a;
  wire  [BUS_W-1:0]  sram_d;
  logic              sram_ce_n, sram_oe_n, sram_we_n;
  logic [LANES-1:0]  sram_be_n;

  int tests = 0;
  int fails = 0;
  int done_pulses = 0;
  int wr_events = 0;

  typedef struct {
    bit         is_read;
    logic [7:0] data;
    string      name;
  } exp_t;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  sram_ctrl #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .WAIT_CYCLES(1)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req       (req),
    .we        (we),
    .address   (address),
    .indata    (indata),
    .ready     (ready),
    .ack       (ack),
    .outdata   (outdata),
    .prog      (prog),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .prog_busy (prog_busy),
    .prog_done (prog_done),
    .SRAM_A    (sram_a),
    .SRAM_D    (sram_d),
    .SRAM_CE_n (sram_ce_n),
    .SRAM_OE_n (sram_oe_n),
    .SRAM_WE_n (sram_we_n),
    .SRAM_BE_n (sram_be_n)
  );

  // SRAM model: byte address {A, 0} on D[15:8], {A, 1} on D[7:0].
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  assign sram_d = !sram_oe_n ? {mem[{sram_a, 1'b0}], mem[{sram_a, 1'b1}]} : 16'bz;

  always @(posedge clock) begin
    if (!sram_we_n) begin
      if (!sram_be_n[1]) mem[{sram_a, 1'b0}] <= sram_d[15:8];
      if (!sram_be_n[0]) mem[{sram_a, 1'b1}] <= sram_d[7:0];
    end
  end

  always @(negedge sram_we_n) wr_events++;

  // Scoreboard monitor: every ack consumes one expected host access.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (prog_done) done_pulses++;
    if (ack) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_ack: ack=1, required 0 (no host access pending)");
      end else begin
        e = sb_q.pop_front();
        if (e.is_read) begin
          tests++;
          if (outdata !== e.data) begin
            fails++;
            $display("FAIL %s: outdata=%02h, required %02h", e.name, outdata, e.data);
          end else begin
            $display("[TB] ack %s read outdata=%02h", e.name, outdata);
          end
        end else begin
          $display("[TB] ack %s write", e.name);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Host access: issues one request, checks strobes in the first STROBE
  // cycle and the request-to-ack latency (WAIT_CYCLES+2 = 3 cycles).
  task automatic host_access(input logic w, input logic [ADDR_W-1:0] a,
                             input logic [7:0] d, input string name,
                             input logic [LANES-1:0] exp_be);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!ready) begin
      check({name, "_ready_timeout"}, 32'(ready), 32'h1);
      return;
    end
    req = 1'b1;
    we = w;
    address = a;
    indata = d;
    e.is_read = !w;
    e.data = d;
    e.name = name;
    sb_q.push_back(e);
    $display("[TB] host %s we=%0b addr=%05h data=%02h", name, w, a, d);
    @(posedge clock);
    #1 req = 1'b0;
    @(negedge clock);
    check({name, "_be_n"}, 32'(sram_be_n), 32'(exp_be));
    check({name, w ? "_we_n" : "_oe_n"}, 32'(w ? sram_we_n : sram_oe_n), 32'h0);
    n = 1;
    while (!ack && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({name, "_ack_latency"}, 32'(n), 32'd3);
  endtask

  // Loader byte: call at a negedge; returns at the negedge after acceptance.
  task automatic ld_byte(input logic [7:0] b, output int waits);
    waits = 0;
    ld_valid = 1'b1;
    ld_data = b;
    while (!ld_ready && waits < 50) begin
      @(negedge clock);
      waits++;
    end
    @(posedge clock);
    #1 ld_valid = 1'b0;
    @(negedge clock);
    $display("[TB] loader byte %02h accepted after %0d wait cycles", b, waits);
  endtask

  task automatic ld_header(input logic [31:0] addr, input logic [31:0] cnt, input string name);
    logic [63:0] hdr;
    int w, wmax;
    hdr = {addr, cnt};
    wmax = 0;
    for (int i = 0; i < 8; i++) begin
      ld_byte(hdr[63-8*i -: 8], w);
      if (w > wmax) wmax = w;
    end
    check({name, "_hdr_no_wait"}, 32'(wmax), 32'h0);
  endtask

  task automatic wait_prog_done(input int target, input string name);
    int n;
    n = 0;
    while (done_pulses < target && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({name, "_prog_done"}, 32'(done_pulses), 32'(target));
    repeat (4) @(negedge clock);
    check({name, "_prog_done_once"}, 32'(done_pulses), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int w, base, wr0;

    // Reset values
    #12;
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_outdata", 32'(outdata), 32'h0);
    check("rst_ld_ready", 32'(ld_ready), 32'h0);
    check("rst_prog_busy_done", 32'({prog_busy, prog_done}), 32'h0);
    check("rst_strobes", 32'({sram_oe_n, sram_we_n, sram_be_n}), 32'hF);
    @(negedge clock);
    resetn = 1'b1;
    #1 check("ready_first_cycle", 32'(ready), 32'h0);
    @(negedge clock);
    check("ready_after_first", 32'(ready), 32'h1);

    // Host write/read and lane mapping
    host_access(1'b1, 19'h00003, 8'h5A, "wr_03", 2'b10);
    host_access(1'b0, 19'h00003, 8'h5A, "rd_03", 2'b10);
    host_access(1'b1, 19'h00010, 8'h11, "wr_10", 2'b01);
    host_access(1'b1, 19'h00011, 8'h22, "wr_11", 2'b10);
    host_access(1'b0, 19'h00010, 8'h11, "rd_10", 2'b01);
    host_access(1'b0, 19'h00011, 8'h22, "rd_11", 2'b10);

    // Loader owns the engine: host requests are ignored
    @(negedge clock);
    prog = 1'b1;
    req = 1'b1;
    we = 1'b0;
    address = 19'h00003;
    #1 check("prog_ready_low", 32'(ready), 32'h0);
    repeat (4) @(negedge clock);
    req = 1'b0;
    check("prog_ld_ready_hdr", 32'(ld_ready), 32'h1);

    // Stream 1: 3 bytes at 0x100
    ld_header(32'h0000_0100, 32'd3, "s1");
    check("s1_prog_busy", 32'(prog_busy), 32'h1);
    base = done_pulses;
    ld_byte(8'hAA, w);
    ld_byte(8'hBB, w);
    check("s1_ld_ready_low_in_flight", 32'(w), 32'd3);
    ld_byte(8'hCC, w);
    wait_prog_done(base + 1, "s1");
    check("s1_mem_100", 32'(mem[19'h00100]), 32'hAA);
    check("s1_mem_101", 32'(mem[19'h00101]), 32'hBB);
    check("s1_mem_102", 32'(mem[19'h00102]), 32'hCC);
    check("s1_busy_after", 32'(prog_busy), 32'h0);

    // Zero-count header, then count 1 with data 0x77
    wr0 = wr_events;
    base = done_pulses;
    ld_header(32'h0, 32'h0, "z0");
    check("z0_prog_done_pulse", 32'(prog_done), 32'h1);
    check("z0_prog_busy", 32'(prog_busy), 32'h0);
    ld_header(32'h0000_0200, 32'd1, "z1");
    ld_byte(8'h77, w);
    wait_prog_done(base + 2, "z1");
    check("z1_mem_200", 32'(mem[19'h00200]), 32'h77);
    check("z_write_count", 32'(wr_events - wr0), 32'd1);

    // Address wrap
    base = done_pulses;
    ld_header(32'h0007_FFFF, 32'd2, "wrap");
    ld_byte(8'hE1, w);
    ld_byte(8'hE2, w);
    wait_prog_done(base + 1, "wrap");
    check("wrap_mem_7ffff", 32'(mem[19'h7FFFF]), 32'hE1);
    check("wrap_mem_00000", 32'(mem[19'h00000]), 32'hE2);

    // Host ownership back; read loader data through the engine
    @(negedge clock);
    prog = 1'b0;
    #1 check("prog_off_ld_ready", 32'(ld_ready), 32'h0);
    host_access(1'b0, 19'h00101, 8'hBB, "rd_101", 2'b10);

    // Asynchronous reset during a write strobe
    @(negedge clock);
    req = 1'b1;
    we = 1'b1;
    address = 19'h00020;
    indata = 8'hC3;
    $display("[TB] host wr_20_abort we=1 addr=00020 data=c3 (reset during strobe)");
    @(posedge clock);
    #1 req = 1'b0;
    @(negedge clock);
    check("abort_we_n_active", 32'(sram_we_n), 32'h0);
    #1 resetn = 1'b0;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'h1);
    check("abort_oe_be", 32'({sram_oe_n, sram_be_n}), 32'h7);
    check("abort_d_released", 32'(sram_d === 16'hC3C3), 32'h0);
    check("abort_outdata", 32'(outdata), 32'h0);
    check("abort_ready", 32'(ready), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    #1 check("abort_ready_first_cycle", 32'(ready), 32'h0);
    @(negedge clock);
    check("abort_ready_after", 32'(ready), 32'h1);
    repeat (5) @(negedge clock);
    host_access(1'b1, 19'h00020, 8'h99, "wr_20", 2'b01);
    host_access(1'b0, 19'h00020, 8'h99, "rd_20", 2'b01);
    repeat (3) @(negedge clock);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
